// File: rtl/rv32imf_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// rv32imf_instr_mem_responder
//
// Responder end of the core's instruction-fetch req/gnt/rvalid interface.
// It holds a word-addressed instruction memory, grants fetch requests and
// returns read data (or a bus error) strictly in grant order after a
// configurable minimum latency. The number of outstanding requests is bounded.
// A backdoor write port preloads program images.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   instr_req_i      fetch request (address phase)
//   instr_addr_i     fetch byte address (bits [1:0] ignored)
//   instr_gnt_o      request accepted this cycle (combinational)
//   instr_rvalid_o   response valid, one cycle per granted request
//   instr_rdata_o    response data (holds last value when rvalid=0)
//   instr_err_o      bus error for this response (address out of range)
//   instr_err_pmp_o  PMP error, tied to 0
//   load_we_i        backdoor write enable
//   load_addr_i      backdoor byte address (same map as fetch)
//   load_wdata_i     backdoor write data
//   busy_o           one or more requests outstanding
//
// Optional build macro: RV32IMF_IMEM_RANDOM_STALL_EN
//   When defined, a 16-bit LFSR randomly withholds grants and delays the
//   head response. Without it, timing is fully deterministic.
// -----------------------------------------------------------------------------
module rv32imf_instr_mem_responder #(
  parameter int unsigned MEM_DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned RSP_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING  = 2,
  parameter int unsigned GNT_STALL_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        instr_err_pmp_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        busy_o
);

  localparam int          AW    = $clog2(MEM_DEPTH_WORDS);
  localparam int          QD    = int'(MAX_OUTSTANDING);
  localparam int          QW    = (QD > 1) ? $clog2(QD) : 1;
  localparam int          CW    = $clog2(QD + 1);
  localparam logic [CW-1:0] QMAX  = CW'(QD);
  localparam logic [QW-1:0] QLAST = QW'(QD - 1);
  localparam logic [3:0]  LAT   = 4'(RSP_LATENCY);

  logic [31:0] r_mem [MEM_DEPTH_WORDS];

  logic [31:0] r_q_data [QD];
  logic        r_q_err  [QD];
  logic [3:0]  r_q_age  [QD];
  logic [QW-1:0] r_rd_ptr;
  logic [QW-1:0] r_wr_ptr;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_last_data;
  logic        r_last_err;

  logic          w_fetch_in_range;
  logic          w_load_in_range;
  logic [AW-1:0] w_fetch_idx;
  logic [AW-1:0] w_load_idx;
  logic [31:0]   w_rd_data;
  logic          w_stall_slot;
  logic          w_rand_gnt_block;
  logic          w_rand_rsp_block;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_addr_lsbs;

  // Base is aligned to the memory size, so a range check is a compare of the
  // bits above the word index.
  assign w_fetch_idx      = instr_addr_i[AW+1:2];
  assign w_load_idx       = load_addr_i[AW+1:2];
  assign w_fetch_in_range = (instr_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_load_in_range  = (load_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_rd_data        = w_fetch_in_range ? r_mem[w_fetch_idx] : 32'h0;
  assign w_unused_addr_lsbs = ^{instr_addr_i[1:0], load_addr_i[1:0]};

  // Periodic grant stall: one withheld slot every GNT_STALL_PERIOD cycles.
  generate
    if (GNT_STALL_PERIOD > 0) begin : g_stall
      localparam int          SW    = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
      localparam logic [SW-1:0] SLAST = SW'(GNT_STALL_PERIOD - 1);
      logic [SW-1:0] r_stall_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt == SLAST) begin
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + SW'(1);
        end
      end
      assign w_stall_slot = (r_stall_cnt == SLAST);
    end else begin : g_no_stall
      assign w_stall_slot = 1'b0;
    end
  endgenerate

`ifdef RV32IMF_IMEM_RANDOM_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11.
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end
  assign w_rand_gnt_block = (r_lfsr[1:0] == 2'b00);
  assign w_rand_rsp_block = (r_lfsr[3:2] == 2'b00);
`else
  assign w_rand_gnt_block = 1'b0;
  assign w_rand_rsp_block = 1'b0;
`endif

  // The limit uses the registered count, so a retiring head does not free a
  // slot until the next cycle. Reset also blocks the grant so every output
  // is low while rst is held.
  assign w_push = instr_req_i & ~rst & (r_cnt < QMAX) & ~w_stall_slot & ~w_rand_gnt_block;
  assign w_pop  = (r_cnt != '0) & (r_q_age[r_rd_ptr] >= LAT) & ~w_rand_rsp_block;

  assign instr_gnt_o     = w_push;
  assign instr_rvalid_o  = w_pop;
  assign instr_rdata_o   = w_pop ? r_q_data[r_rd_ptr] : r_last_data;
  assign instr_err_o     = w_pop ? r_q_err[r_rd_ptr]  : r_last_err;
  assign instr_err_pmp_o = 1'b0;
  assign busy_o          = (r_cnt != '0);

  // Queue control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_last_data <= 32'h0;
      r_last_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == QLAST) ? '0 : r_wr_ptr + QW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= (r_rd_ptr == QLAST) ? '0 : r_rd_ptr + QW'(1);
        r_last_data <= r_q_data[r_rd_ptr];
        r_last_err  <= r_q_err[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Queue payload. An entry is written with age 1 because by the time it is
  // visible it is already one cycle past its grant; ages saturate at LAT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QD; i++) begin
      if (r_q_age[i] < LAT) begin
        r_q_age[i] <= r_q_age[i] + 4'd1;
      end
    end
    if (w_push) begin
      r_q_data[r_wr_ptr] <= w_rd_data;
      r_q_err[r_wr_ptr]  <= ~w_fetch_in_range;
      r_q_age[r_wr_ptr]  <= 4'd1;
    end
  end

  // Backdoor write. The fetch read above is sampled in the same edge, so a
  // same-cycle fetch of this word captures the old contents.
  always_ff @(posedge clk) begin
    if (load_we_i && w_load_in_range) begin
      r_mem[w_load_idx] <= load_wdata_i;
    end
  end

endmodule

// File: tb/tb_rv32imf_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for rv32imf_instr_mem_responder. Two instances: A (latency 1) and
// B (latency 3), both with two outstanding requests. A transaction-level
// model (memory array plus a queue of {data, err, grant cycle}) predicts every
// output on every falling edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_rv32imf_instr_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          gcyc;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        pmp    [2];
  logic        busy   [2];
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;

  int errors = 0;
  int checks = 0;

  rv32imf_instr_mem_responder #(.RSP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]),
    .instr_rdata_o(rdata[0]), .instr_err_o(err[0]), .instr_err_pmp_o(pmp[0]),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .busy_o(busy[0])
  );

  rv32imf_instr_mem_responder #(.RSP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]),
    .instr_rdata_o(rdata[1]), .instr_err_o(err[1]), .instr_err_pmp_o(pmp[1]),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // ---------------- model + per-cycle compare ----------------
  logic [31:0] mmem [4096];
  txn_t        mq   [2][$];
  int          cyc = 0;

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = 32'h0;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'd0);
        chk($sformatf("rst_rvalid%0d", d), 32'(rvalid[d]), 32'd0);
        chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
        chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
        chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
        mq[d].delete();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit   eg, ev;
        txn_t t;
        eg = req[d] && (mq[d].size() < 2);
        ev = (mq[d].size() > 0) && ((cyc - mq[d][0].gcyc) >= lat(d));
        chk($sformatf("m_gnt%0d", d), 32'(gnt[d]), 32'(eg));
        chk($sformatf("m_rvalid%0d", d), 32'(rvalid[d]), 32'(ev));
        chk($sformatf("m_busy%0d", d), 32'(busy[d]), 32'(mq[d].size() != 0));
        chk($sformatf("m_pmp%0d", d), 32'(pmp[d]), 32'd0);
        if (ev) begin
          chk($sformatf("m_rdata%0d", d), rdata[d], mq[d][0].data);
          chk($sformatf("m_err%0d", d), 32'(err[d]), 32'(mq[d][0].err));
          void'(mq[d].pop_front());
        end
        if (eg) begin
          t.gcyc = cyc;
          t.err  = (addr[d] >= 32'h4000);
          t.data = t.err ? 32'h0 : mmem[addr[d][13:2]];
          mq[d].push_back(t);
        end
      end
      if (load_we && load_addr < 32'h4000) mmem[load_addr[13:2]] = load_wdata;
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] gnt_pat;
  logic [4:0] rv_pat;

  initial begin
    rst = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    addr[0] = 32'h0; addr[1] = 32'h0;
    load_we = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
    gnt_pat = 5'b10011;
    rv_pat  = 5'b11000;
    step(); step();
    chk("reset_rvalid", 32'(rvalid[0]), 32'd0);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    rst = 1'b0;

    // Preload words 0..15 with 0x1000_00nn, word 0x10 with DEAD_BEEF.
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 32'(i * 4); load_wdata = 32'h1000_0000 + 32'(i);
      step();
    end
    load_addr = 32'h40; load_wdata = 32'hDEAD_BEEF;
    step();
    load_we = 1'b0;

    // Single fetch, latency 1.
    req[0] = 1'b1; addr[0] = 32'h40;
    #2 chk("t1_gnt", 32'(gnt[0]), 32'd1);
    step(); req[0] = 1'b0;
    #2 chk("t1_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t1_rdata", rdata[0], 32'hDEAD_BEEF);
    chk("t1_err", 32'(err[0]), 32'd0);
    step();

    // Four back-to-back fetches, one grant and one response per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin req[0] = 1'b1; addr[0] = 32'(i * 4); end
      else req[0] = 1'b0;
      #2;
      if (i < 4) chk($sformatf("t2_gnt%0d", i), 32'(gnt[0]), 32'd1);
      if (i > 0) begin
        chk($sformatf("t2_rvalid%0d", i), 32'(rvalid[0]), 32'd1);
        chk($sformatf("t2_rdata%0d", i), rdata[0], 32'h1000_0000 + 32'(i - 1));
      end
      step();
    end

    // Latency 3, request held: queue fills, grant resumes after first rvalid.
    req[1] = 1'b1; addr[1] = 32'h4;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("t3_gnt%0d", i), 32'(gnt[1]), 32'(gnt_pat[i]));
      chk($sformatf("t3_rvalid%0d", i), 32'(rvalid[1]), 32'(rv_pat[i]));
      if (rv_pat[i]) chk($sformatf("t3_rdata%0d", i), rdata[1], 32'h1000_0001);
      step();
    end
    req[1] = 1'b0;
    repeat (6) step();

    // Out-of-range fetch, then an in-range one.
    req[0] = 1'b1; addr[0] = 32'h4000;
    #2 chk("t4_gnt", 32'(gnt[0]), 32'd1);
    step(); addr[0] = 32'h8;
    #2 chk("t4_err_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t4_err", 32'(err[0]), 32'd1);
    chk("t4_err_rdata", rdata[0], 32'h0);
    step(); req[0] = 1'b0;
    #2 chk("t4_ok_err", 32'(err[0]), 32'd0);
    chk("t4_ok_rdata", rdata[0], 32'h1000_0002);
    step();

    // Fetch and backdoor write of the same word in one cycle.
    req[0] = 1'b1; addr[0] = 32'h20;
    load_we = 1'b1; load_addr = 32'h20; load_wdata = 32'h1234_5678;
    #2 chk("t5_gnt", 32'(gnt[0]), 32'd1);
    step(); load_we = 1'b0;
    #2 chk("t5_old_rdata", rdata[0], 32'h1000_0008);
    step(); req[0] = 1'b0;
    #2 chk("t5_new_rdata", rdata[0], 32'h1234_5678);
    step();

    // Reset with two requests outstanding on instance B.
    req[1] = 1'b1; addr[1] = 32'h0;
    step(); step();
    req[1] = 1'b0;
    #1 chk("t6_busy_before", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t6_rvalid%0d", d), 32'(rvalid[d]), 32'd0);
      chk($sformatf("t6_gnt%0d", d), 32'(gnt[d]), 32'd0);
      chk($sformatf("t6_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("t6_rdata%0d", d), rdata[d], 32'd0);
      chk($sformatf("t6_err%0d", d), 32'(err[d]), 32'd0);
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2 chk($sformatf("t6_stale_rvalid%0d", i), 32'(rvalid[1]), 32'd0);
      chk($sformatf("t6_post_busy%0d", i), 32'(busy[1]), 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
